// File: rtl/scan_pkg.sv
// Shared types and constants for the scan-chain loader.
// Chain layout, CRC polynomial and the bit-serial CRC-8 step used when SCAN_LOADER_CRC_EN is set.
package scan_pkg;

  localparam int MEM_SIZE      = 15;
  localparam int DATA_WIDTH    = 8;
  localparam int BTN_W         = 1;
  localparam int LED_W         = 7;
  localparam int KEY_W         = 16;
  localparam int CHAIN_LEN_DEF = MEM_SIZE * DATA_WIDTH + BTN_W + LED_W + KEY_W;

  localparam int         CRC_W    = 8;
  localparam logic [7:0] CRC_POLY = 8'h07;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // MSB-first serial CRC: feedback is the outgoing MSB xor the incoming bit.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
    logic fb;
    fb = crc[7] ^ bit_in;
    return {crc[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 accumulator (init 0x00); clr restarts it, en folds in one bit.
module crc8_serial
  import scan_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [7:0] crc
);

  always_ff @(posedge clk) begin
    if (rst || clr) crc <= 8'h00;
    else if (en)    crc <= crc8_step(crc, bit_in);
  end

endmodule

// File: rtl/scan_chain_loader.sv
// Serial program loader in front of the memory bank scan chain: one chain shift per
// accepted bit, displaced bits returned as readback. Optional CRC trailer check: SCAN_LOADER_CRC_EN.
module scan_chain_loader
  import scan_pkg::*;
#(
  parameter int CHAIN_LEN = CHAIN_LEN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic prog_start,
  input  logic prog_data,
  input  logic prog_valid,
  output logic prog_ready,
  output logic chain_scan_enable,
  output logic chain_scan_in,
  input  logic chain_scan_out,
  output logic rb_bit,
  output logic rb_valid,
  output logic cpu_halt,
  output logic busy,
  output logic done,
  output logic error
);

  localparam int CNT_WIDTH = $clog2(CHAIN_LEN + 1);
  localparam int STAGES    = 1;

  state_t                 state, state_nxt;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [STAGES:0]        vld_pipe;
  logic                   accept, shift_acc, check_acc, last_bit, start;

  assign accept    = prog_valid && prog_ready;
  assign shift_acc = accept && (state == ST_SHIFT);
  assign check_acc = accept && (state == ST_CHECK);
  assign last_bit  = (cnt == CNT_WIDTH'(CHAIN_LEN - 1));
  assign start     = prog_start && ((state == ST_IDLE) || (state == ST_DONE));

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (prog_start) state_nxt = ST_SHIFT;
`ifdef SCAN_LOADER_CRC_EN
      ST_SHIFT: if (shift_acc && last_bit) state_nxt = ST_CHECK;
      ST_CHECK: if (check_acc && cnt == CNT_WIDTH'(CRC_W - 1)) state_nxt = ST_DONE;
`else
      ST_SHIFT: if (shift_acc && last_bit) state_nxt = ST_DONE;
`endif
      ST_DONE:  if (prog_start) state_nxt = ST_SHIFT;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Ready is masked by rst so a reset cycle can never shift the chain.
  always_comb begin
    prog_ready        = 1'b0;
    busy              = 1'b0;
    cpu_halt          = 1'b0;
    done              = 1'b0;
    chain_scan_enable = 1'b0;
    chain_scan_in     = prog_data;
    case (state)
      ST_SHIFT: begin
        prog_ready        = !rst;
        busy              = 1'b1;
        cpu_halt          = 1'b1;
        chain_scan_enable = shift_acc;
      end
      ST_CHECK: begin
        prog_ready = !rst;
        busy       = 1'b1;
        cpu_halt   = 1'b1;
      end
      ST_DONE: begin
        done     = 1'b1;
        cpu_halt = error;
      end
      default: ;
    endcase
  end

  // Counter doubles as the trailer bit index while in CHECK.
  always_ff @(posedge clk) begin
    if (rst)            cnt <= '0;
    else if (start)     cnt <= '0;
    else if (shift_acc) cnt <= last_bit ? '0 : cnt + 1'b1;
    else if (check_acc) cnt <= cnt + 1'b1;
  end

  assign vld_pipe[0] = shift_acc;
  assign rb_valid    = vld_pipe[STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe[STAGES:1] <= '0;
      rb_bit             <= 1'b0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      if (shift_acc) rb_bit <= chain_scan_out;
    end
  end

`ifdef SCAN_LOADER_CRC_EN
  logic [7:0] crc, trailer;
  logic       error_q;

  crc8_serial u_crc (
    .clk    (clk),
    .rst    (rst),
    .clr    (start),
    .en     (shift_acc),
    .bit_in (prog_data),
    .crc    (crc)
  );

  always_ff @(posedge clk) begin
    if (rst || start) begin
      trailer <= 8'h00;
      error_q <= 1'b0;
    end else if (check_acc) begin
      trailer <= {trailer[6:0], prog_data};
      if (cnt == CNT_WIDTH'(CRC_W - 1)) error_q <= ({trailer[6:0], prog_data} != crc);
    end
  end

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

endmodule

// File: doc/scan_chain_loader.md
Name: scan_chain_loader

Overview:
Serial programming front-end that sits directly upstream of the memory bank's scan chain.
- Accepts a bit-serial program image over a valid/ready handshake.
- Drives the chain's scan_enable/scan_in so that exactly one chain shift occurs per accepted bit.
- Returns the displaced chain contents as a readback stream.
- Holds the CPU halted while loading, and flags completion (and checksum errors when enabled).

Parameters:
- CHAIN_LEN, 144, total scan-chain bits: 15 memory bytes x 8 + 1 button + 7 LED + 16 key.
- CNT_WIDTH, $clog2(CHAIN_LEN+1), bit-counter width; derived, not overridden.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- prog_start  in  1  one-cycle pulse that begins a load
- prog_data  in  1  serial program bit
- prog_valid  in  1  prog_data is valid
- prog_ready  out  1  loader accepts prog_data this cycle
- chain_scan_enable  out  1  to memory bank scan_enable
- chain_scan_in  out  1  to memory bank scan_in
- chain_scan_out  in  1  from memory bank scan_out (bit leaving the chain)
- rb_bit  out  1  readback bit
- rb_valid  out  1  rb_bit valid; one-cycle pulse, no backpressure
- cpu_halt  out  1  CPU must not execute or write memory
- busy  out  1  load in progress
- done  out  1  load finished; sticky
- error  out  1  checksum mismatch; sticky, 0 when feature is off

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values:
  - FSM = IDLE, counter = 0, rb_valid = 0, rb_bit = 0.
  - done = 0, error = 0, busy = 0, cpu_halt = 0, prog_ready = 0.
- States: IDLE, SHIFT, CHECK (feature only), DONE.
- IDLE:
  - prog_ready = 0.
  - prog_start -> SHIFT; counter cleared; done/error cleared.
- SHIFT:
  - prog_ready = 1; busy = 1; cpu_halt = 1.
  - Accept = prog_valid && prog_ready.
  - chain_scan_enable = Accept (combinational); chain_scan_in = prog_data (combinational).
  - No shift occurs on cycles with prog_valid = 0; stalls of any length are allowed.
  - On Accept: rb_bit <= chain_scan_out and rb_valid <= 1 (1-cycle latency); counter += 1.
  - On the Accept where counter == CHAIN_LEN-1: -> CHECK if feature enabled, else -> DONE.
- Bit ordering: the first accepted bit ends at the far (key) end of the chain after CHAIN_LEN shifts; the last accepted bit lands in memory cell 0 bit 0 position.
- DONE:
  - done = 1; busy = 0; prog_ready = 0; chain_scan_enable = 0.
  - cpu_halt = error (halt is held on a failed load).
  - prog_start -> SHIFT (reload allowed).
- prog_start while in SHIFT/CHECK: ignored.
- prog_valid outside SHIFT/CHECK: ignored; no shift.
- Reset mid-load: immediately IDLE. Chain contents are left partially shifted and are not restored. done = 0.
- Simultaneous rst and prog_start: rst wins.
- chain_scan_enable is never asserted outside SHIFT.

Optional Feature:
- Macro: SCAN_LOADER_CRC_EN.
- Enabled:
  - A CRC-8 (poly 0x07, init 0x00, MSB-first bit-serial) runs over every payload bit accepted in SHIFT.
  - CHECK state: prog_ready = 1, chain_scan_enable = 0; accepts 8 trailer bits MSB-first into a compare register; no readback pulses.
  - After the 8th trailer bit -> DONE; error = (trailer != CRC).
- Disabled: no CHECK state, no CRC logic; error is tied to 0.

Decomposition:
- Shared package scan_pkg:
  - state enum.
  - CHAIN_LEN default constant derived from MEM_SIZE, DATA_WIDTH, and the IO/key widths.
  - CRC_POLY = 8'h07.
- Sub-module crc8_serial (clk, rst, clr, en, bit_in, crc), instantiated only under SCAN_LOADER_CRC_EN.

Test Plan:
- Full load, no stalls:
  - Stimulus: prog_start, then 144 bits (mem byte 0 = 8'hA5, key = 16'hBEEF).
  - Response: chain_scan_enable high for exactly 144 cycles; done = 1 on the cycle after the last accept; memory reads 8'hA5 at address 0; locking_key = 16'hBEEF; cpu_halt drops.
- Stalls:
  - Stimulus: same image with prog_valid deasserted every 3rd cycle.
  - Response: identical final chain state; chain_scan_enable = 0 on stall cycles; counter frozen.
- Readback:
  - Stimulus: preload the chain with pattern P, then load zeros.
  - Response: the 144 rb_valid pulses reproduce P in chain order, each one cycle after its accept.
- Reset mid-load:
  - Stimulus: rst after 50 bits.
  - Response: next cycle state = IDLE; busy = 0, done = 0, prog_ready = 0; no further chain shifts.
- Restart and ignore:
  - Stimulus: prog_start during SHIFT (bit 70), then a second prog_start in DONE.
  - Response: the first is ignored with 144 shifts total; the second starts a fresh load and clears done.
- CRC (macro on):
  - Stimulus: correct trailer.
  - Response: error = 0, cpu_halt = 0.
  - Stimulus: trailer with 1 bit flipped.
  - Response: error = 1, cpu_halt stays 1 until the next prog_start.
